// File: rtl/trojan_bench_pkg.sv
// Shared types and defaults for the exhaustive pattern / signature bench stage.
//   state_t          : sequencer states (IDLE, SETTLE, CAPTURE, DONE)
//   DEFAULT_SIG_POLY : default MISR feedback polynomial (CRC-16-CCITT taps)
//   DEFAULT_SIG_SEED : default signature start value
package trojan_bench_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_SIG_SEED = 16'h0000;

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register. Each enabled cycle shifts the signature left, folds in
// the polynomial when the outgoing MSB is set, and XORs in the zero-extended response.
//   CK        in  clock, rising edge
//   reset     in  asynchronous, active-high; signature returns to SIG_SEED
//   clear     in  load seed (wins over enable)
//   seed      in  value loaded by clear
//   enable    in  compact data into the signature this cycle
//   data      in  response word, N_OUT bits
//   signature out current signature
module misr_compactor
  import trojan_bench_pkg::*;
#(
  parameter int unsigned       SIG_W    = 16,
  parameter int unsigned       N_OUT    = 1,
  parameter logic [SIG_W-1:0]  SIG_POLY = SIG_W'(DEFAULT_SIG_POLY),
  parameter logic [SIG_W-1:0]  SIG_SEED = SIG_W'(DEFAULT_SIG_SEED)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clear,
  input  logic [SIG_W-1:0] seed,
  input  logic             enable,
  input  logic [N_OUT-1:0] data,
  output logic [SIG_W-1:0] signature
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] feedback;

  assign data_ext = SIG_W'(data);
  assign feedback = sig_q[SIG_W-1] ? SIG_POLY : '0;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = seed;
    end else if (enable) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_q <= SIG_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/exhaustive_pattern_signature.sv
// Stimulus/response stage wrapped around a combinational DUT. Walks every N_IN-bit pattern in
// ascending order, holds each for SETTLE_CYCLES cycles, captures the response, compacts it
// into a MISR signature and streams (pattern, response) pairs.
//   CK           in  clock, rising edge
//   reset        in  asynchronous, active-high
//   start        in  begin a run (honoured only in IDLE or DONE)
//   dut_in       out pattern driven to the DUT
//   dut_out      in  DUT response, sampled only in CAPTURE
//   busy         out high in SETTLE and CAPTURE
//   done         out high in DONE until next start or reset
//   signature    out MISR value, final once done is high
//   cap_valid    out one-cycle pulse per captured pattern
//   cap_pattern  out pattern belonging to cap_valid
//   cap_response out response belonging to cap_valid
module exhaustive_pattern_signature
  import trojan_bench_pkg::*;
#(
  parameter int unsigned      N_IN          = 3,
  parameter int unsigned      N_OUT         = 1,
  parameter int unsigned      SETTLE_CYCLES = 1,
  parameter int unsigned      SIG_W         = 16,
  parameter logic [SIG_W-1:0] SIG_POLY      = SIG_W'(DEFAULT_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED      = SIG_W'(DEFAULT_SIG_SEED)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             cap_valid,
  output logic [N_IN-1:0]  cap_pattern,
  output logic [N_OUT-1:0] cap_response
);

  // Counter value on the final SETTLE cycle of a pattern.
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cap_valid_q, cap_valid_d;
  logic [N_IN-1:0]  cap_pattern_q, cap_pattern_d;
  logic [N_OUT-1:0] cap_response_q, cap_response_d;
  logic             misr_clear;
  logic             misr_enable;

  always_comb begin
    state_d        = state_q;
    dut_in_d       = dut_in_q;
    settle_cnt_d   = settle_cnt_q;
    done_d         = done_q;
    cap_valid_d    = 1'b0;
    cap_pattern_d  = cap_pattern_q;
    cap_response_d = cap_response_q;
    misr_clear     = 1'b0;
    misr_enable    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          misr_clear   = 1'b1;
          dut_in_d     = '0;
          settle_cnt_d = '0;
          done_d       = 1'b0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 8'd1;
        if (settle_cnt_q == SettleLast) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        misr_enable    = 1'b1;
        cap_valid_d    = 1'b1;
        cap_pattern_d  = dut_in_q;
        cap_response_d = dut_out;
        // Last pattern parks dut_in rather than wrapping to zero.
        if (dut_in_q == '1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          dut_in_d     = dut_in_q + 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CAPTURE);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      dut_in_q       <= '0;
      settle_cnt_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cap_valid_q    <= 1'b0;
      cap_pattern_q  <= '0;
      cap_response_q <= '0;
    end else begin
      state_q        <= state_d;
      dut_in_q       <= dut_in_d;
      settle_cnt_q   <= settle_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cap_valid_q    <= cap_valid_d;
      cap_pattern_q  <= cap_pattern_d;
      cap_response_q <= cap_response_d;
    end
  end

  misr_compactor #(
    .SIG_W    (SIG_W),
    .N_OUT    (N_OUT),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .CK        (CK),
    .reset     (reset),
    .clear     (misr_clear),
    .seed      (SIG_SEED),
    .enable    (misr_enable),
    .data      (dut_out),
    .signature (signature)
  );

  assign dut_in       = dut_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cap_valid    = cap_valid_q;
  assign cap_pattern  = cap_pattern_q;
  assign cap_response = cap_response_q;

endmodule

// File: tb/tb_exhaustive_pattern_signature.sv
module tb_exhaustive_pattern_signature;

  logic        CK = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  dut_in;
  logic [0:0]  dut_out;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        cap_valid;
  logic [2:0]  cap_pattern;
  logic [0:0]  cap_response;

  int total = 0;
  int bad   = 0;
  int out_mode = 0;  // 0: tied 0, 1: tied 1, 2: dut_in[0]

  // Scoreboard entries are {pattern, response}.
  logic [3:0] sb_q[$];

  always #5 CK = ~CK;

  assign dut_out = (out_mode == 0) ? 1'b0 : (out_mode == 1) ? 1'b1 : dut_in[0];

  exhaustive_pattern_signature #(
    .N_IN          (3),
    .N_OUT         (1),
    .SETTLE_CYCLES (1),
    .SIG_W         (16),
    .SIG_POLY      (16'h1021),
    .SIG_SEED      (16'h0000)
  ) dut (
    .CK           (CK),
    .reset        (reset),
    .start        (start),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .cap_valid    (cap_valid),
    .cap_pattern  (cap_pattern),
    .cap_response (cap_response)
  );

  function automatic logic model_resp(input int mode, input logic [2:0] p);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return p[0];
  endfunction

  task automatic push_expected();
    sb_q.delete();
    for (int p = 0; p < 8; p++) begin
      logic [2:0] pat;
      pat = 3'(p);
      sb_q.push_back({pat, model_resp(out_mode, pat)});
    end
  endtask

  // Returns #1 after edge E0.
  task automatic pulse_start();
    @(negedge CK);
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input logic [15:0] exp_sig, input bit inject);
    logic [2:0] prev;
    logic [3:0] exp_e, got_e;
    bit         injected, seen_done;
    int         caps;
    prev = 3'd0; injected = 0; seen_done = 0; caps = 0;
    for (int cyc = 1; cyc <= 100 && !seen_done; cyc++) begin
      @(posedge CK);
      #1;
      if (start) start = 1'b0;
      if (inject && !injected && dut_in == 3'd3 && busy) begin
        start = 1'b1;
        injected = 1;
      end
      total++;
      if (busy !== ~done) begin
        bad++;
        $display("FAIL %s busy cyc=%0d busy=%b done=%b", tag, cyc, busy, done);
      end
      total++;
      if (dut_in < prev) begin
        bad++;
        $display("FAIL %s no_wrap cyc=%0d dut_in=%0d prev=%0d", tag, cyc, dut_in, prev);
      end
      prev = dut_in;
      if (cap_valid === 1'b1) begin
        caps++;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_cap cyc=%0d got=%0d/%0d expected none", tag, cyc, cap_pattern,
                   cap_response);
        end else begin
          exp_e = sb_q.pop_front();
          got_e = {cap_pattern, cap_response};
          if (got_e !== exp_e) begin
            bad++;
            $display("FAIL %s cap cyc=%0d got=%0d/%0d expected=%0d/%0d", tag, cyc, got_e[3:1],
                     got_e[0], exp_e[3:1], exp_e[0]);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        total++;
        if (cyc != 16) begin
          bad++;
          $display("FAIL %s done_time got=E0+%0d expected=E0+16", tag, cyc);
        end
      end
    end
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL %s timeout done=%b expected 1 within 100 cycles", tag, done);
    end
    total++;
    if (caps != 8 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s cap_count got=%0d left=%0d expected=8 left=0", tag, caps, sb_q.size());
    end
    total++;
    if (signature !== exp_sig) begin
      bad++;
      $display("FAIL %s signature got=%h expected=%h", tag, signature, exp_sig);
    end
    total++;
    if (dut_in !== 3'd7 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end_state dut_in=%0d busy=%b expected 7/0", tag, dut_in, busy);
    end
    @(posedge CK);
    #1;
    total++;
    if (cap_valid !== 1'b0 || done !== 1'b1 || signature !== exp_sig || dut_in !== 3'd7) begin
      bad++;
      $display("FAIL %s hold cap_valid=%b done=%b sig=%h dut_in=%0d expected 0/1/%h/7", tag,
               cap_valid, done, signature, exp_sig, dut_in);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_mode = 0;
    #12;
    total++;
    if ({dut_in, busy, done, cap_valid, cap_pattern, cap_response} !== 10'd0
        || signature !== 16'h0000) begin
      bad++;
      $display("FAIL reset_values dut_in=%0d busy=%b done=%b cap=%b/%0d/%0d sig=%h expected 0s",
               dut_in, busy, done, cap_valid, cap_pattern, cap_response, signature);
    end
    @(negedge CK);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      out_mode = i % 3;
      @(posedge CK);
      #1;
      total++;
      if (dut_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || cap_valid !== 1'b0
          || signature !== 16'h0000) begin
        bad++;
        $display("FAIL idle cyc=%0d dut_in=%0d busy=%b done=%b cap_valid=%b sig=%h expected 0s",
                 i, dut_in, busy, done, cap_valid, signature);
      end
    end
  endtask

  task automatic test_tied(input int mode, input logic [15:0] exp_sig, input string tag);
    out_mode = mode;
    push_expected();
    pulse_start();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || dut_in !== 3'd0) begin
      bad++;
      $display("FAIL %s after_e0 busy=%b done=%b dut_in=%0d expected 1/0/0", tag, busy, done,
               dut_in);
    end
    run_to_done(tag, exp_sig, 1'b0);
  endtask

  task automatic test_start_while_busy();
    out_mode = 2;
    push_expected();
    pulse_start();
    run_to_done("start_busy", 16'h0055, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit reached;
    out_mode = 2;
    push_expected();
    pulse_start();
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(posedge CK);
      #1;
      if (dut_in == 3'd5) reached = 1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL mid_reset reach_p5 dut_in=%0d expected 5", dut_in);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({dut_in, busy, done, cap_valid, cap_pattern, cap_response} !== 10'd0
        || signature !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset values dut_in=%0d busy=%b done=%b cap=%b/%0d/%0d sig=%h expected 0s",
               dut_in, busy, done, cap_valid, cap_pattern, cap_response, signature);
    end
    @(negedge CK);
    reset = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset idle done=%b busy=%b expected 0/0", done, busy);
    end
    push_expected();
    pulse_start();
    run_to_done("after_reset", 16'h0055, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Previous run ended done with signature 0x00FF (tied-1), so the reseed is observable.
    out_mode = 1;
    push_expected();
    pulse_start();
    run_to_done("b2b_first", 16'h00FF, 1'b0);
    out_mode = 2;
    push_expected();
    pulse_start();
    total++;
    if (done !== 1'b0 || signature !== 16'h0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart done=%b sig=%h busy=%b expected 0/0000/1", done, signature, busy);
    end
    run_to_done("b2b_second", 16'h0055, 1'b0);
  endtask

  initial begin
    test_reset();
    test_tied(0, 16'h0000, "tied0");
    test_tied(1, 16'h00FF, "tied1");
    test_tied(2, 16'h0055, "alt");
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
